// File: rtl/step_fsm_n.sv
// Parametrised N-state step sequencer: prescaled up/down stepping with wrap,
// saturate and ping-pong boundaries, synchronous load, and binary/Gray/one-hot views.
module step_fsm_n #(
  parameter int N_STATES = 4,
  parameter int W        = 2,
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sw,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic                load,
  input  logic [W-1:0]        load_val,
  output logic [W-1:0]        Q,
  output logic [W-1:0]        Q_gray,
  output logic [N_STATES-1:0] onehot,
  output logic                dir,
  output logic                term
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_PP       = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int            PW      = 16;
  localparam logic [W:0]    LAST    = (W+1)'(N_STATES - 1);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  if (N_STATES < 2 || N_STATES > 256) begin : g_bad_n
    $error("step_fsm_n: N_STATES must be in 2..256");
  end
  if (W < $clog2(N_STATES)) begin : g_bad_w
    $error("step_fsm_n: W too narrow for N_STATES");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_ps
    $error("step_fsm_n: PRESCALE must be in 1..65535");
  end

  logic [W-1:0]  q_q, q_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  dir_e          pp_dir_q, pp_dir_d;
  logic          term_q, term_d;

  mode_e      mode_s;
  logic       fire;
  logic       step_up;
  logic       reverse;
  logic       move_up;
  logic       step_term;
  logic [W:0] q_x;
  logic [W:0] q_step_x;
  logic [W:0] lv_x;

  assign mode_s = mode_e'(mode);
  assign dir    = (mode_s == MODE_PP) ? (pp_dir_q == DIR_DOWN) : sw;
  assign fire   = en && !load && (pcnt_q == PS_LAST);

  // Candidate next state for a step; reverse marks a ping-pong bounce.
  always_comb begin
    q_x       = {1'b0, q_q};
    step_up   = !dir;
    q_step_x  = q_x;
    reverse   = 1'b0;
    case (mode_s)
      MODE_SAT: begin
        if (step_up) begin
          if (q_x != LAST) q_step_x = q_x + 1'b1;
        end else if (q_x != '0) begin
          q_step_x = q_x - 1'b1;
        end
      end
      MODE_PP: begin
        if (step_up) begin
          if (q_x == LAST) begin
            reverse  = 1'b1;
            q_step_x = LAST - 1'b1;
          end else begin
            q_step_x = q_x + 1'b1;
          end
        end else if (q_x == '0) begin
          reverse  = 1'b1;
          q_step_x = (W+1)'(1);
        end else begin
          q_step_x = q_x - 1'b1;
        end
      end
      default: begin
        if (step_up) q_step_x = (q_x == LAST) ? '0 : q_x + 1'b1;
        else         q_step_x = (q_x == '0) ? LAST : q_x - 1'b1;
      end
    endcase
    move_up   = step_up ^ reverse;
    step_term = (q_step_x != q_x) &&
                ((move_up && q_step_x == LAST) || (!move_up && q_step_x == '0));
  end

  // Next-state: load beats step; pcnt only advances while enabled.
  always_comb begin
    q_d      = q_q;
    pcnt_d   = pcnt_q;
    pp_dir_d = pp_dir_q;
    term_d   = 1'b0;
    lv_x     = {1'b0, load_val};
    if (mode_s != MODE_PP) pp_dir_d = sw ? DIR_DOWN : DIR_UP;
    if (load) begin
      q_d    = (lv_x > LAST) ? LAST[W-1:0] : load_val;
      pcnt_d = '0;
    end else if (en) begin
      if (fire) begin
        pcnt_d = '0;
        q_d    = q_step_x[W-1:0];
        term_d = step_term;
        if (reverse) pp_dir_d = (pp_dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q      <= '0;
      pcnt_q   <= '0;
      pp_dir_q <= DIR_UP;
      term_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      pcnt_q   <= pcnt_d;
      pp_dir_q <= pp_dir_d;
      term_q   <= term_d;
    end
  end

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_STATES; i++) begin
      onehot[i] = (q_q == W'(i));
    end
  end

  assign Q      = q_q;
  assign Q_gray = q_q ^ (q_q >> 1);
  assign term   = term_q;

endmodule

// File: tb/tb_step_fsm_n.sv
// Randomised scoreboard bench for step_fsm_n (N_STATES=5, W=3, PRESCALE=3):
// the driver pushes reference-model expectations, a monitor pops and compares each cycle.
module tb_step_fsm_n;

  localparam int N  = 5;
  localparam int WD = 3;
  localparam int P  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          sw;
  logic          en;
  logic [1:0]    mode;
  logic          load;
  logic [WD-1:0] load_val;
  logic [WD-1:0] Q;
  logic [WD-1:0] Q_gray;
  logic [N-1:0]  onehot;
  logic          dir;
  logic          term;

  typedef struct {
    logic [WD-1:0] q;
    logic          term;
    logic          dir;
    logic [WD-1:0] gray;
    logic [N-1:0]  onehot;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle_no = 0;

  int m_q     = 0;
  int m_pcnt  = 0;
  bit m_ppdir = 1'b0;
  bit m_term  = 1'b0;

  step_fsm_n #(.N_STATES(N), .W(WD), .PRESCALE(P)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .Q        (Q),
    .Q_gray   (Q_gray),
    .onehot   (onehot),
    .dir      (dir),
    .term     (term)
  );

  always #5 clk = ~clk;

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cycle_no, act, req);
    end
  endtask

  // Reference model: applies the sequencer's rules to plain integers.
  task automatic applyStimulus(input bit r, input bit l, input bit e, input bit s,
                               input logic [1:0] m, input logic [WD-1:0] lv);
    exp_t x;
    int   old_q;
    bit   fired;
    bit   up;
    reset    = r;
    load     = l;
    en       = e;
    sw       = s;
    mode     = m;
    load_val = lv;
    fired    = 1'b0;
    old_q    = m_q;
    if (r) begin
      m_q = 0; m_pcnt = 0; m_ppdir = 1'b0; m_term = 1'b0;
    end else if (l) begin
      m_q    = (int'(lv) > N - 1) ? N - 1 : int'(lv);
      m_pcnt = 0;
      m_term = 1'b0;
      if (m != 2'b10) m_ppdir = s;
    end else begin
      up = (m == 2'b10) ? !m_ppdir : !s;
      if (e) begin
        if (m_pcnt == P - 1) begin
          fired  = 1'b1;
          m_pcnt = 0;
        end else begin
          m_pcnt++;
        end
      end
      if (fired) begin
        case (m)
          2'b01: begin
            if (up && m_q < N - 1) m_q++;
            else if (!up && m_q > 0) m_q--;
          end
          2'b10: begin
            if (up) begin
              if (m_q == N - 1) begin m_ppdir = 1'b1; m_q = N - 2; end
              else m_q++;
            end else begin
              if (m_q == 0) begin m_ppdir = 1'b0; m_q = 1; end
              else m_q--;
            end
          end
          default: m_q = (m_q + (up ? 1 : N - 1)) % N;
        endcase
      end
      if (m != 2'b10) m_ppdir = s;
      m_term = fired && ((m_q == N - 1 && m_q == old_q + 1) || (m_q == 0 && m_q == old_q - 1));
    end
    x.q      = WD'(m_q);
    x.term   = m_term;
    x.dir    = (m == 2'b10) ? m_ppdir : s;
    x.gray   = WD'(m_q ^ (m_q >> 1));
    x.onehot = N'(1 << m_q);
    exp_q.push_back(x);
  endtask

  task automatic checkOutput();
    exp_t x;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty cycle=%0d actual=0 required=1", cycle_no);
      return;
    end
    x = exp_q.pop_front();
    checkField("Q",      32'(Q),      32'(x.q));
    checkField("term",   32'(term),   32'(x.term));
    checkField("dir",    32'(dir),    32'(x.dir));
    checkField("Q_gray", 32'(Q_gray), 32'(x.gray));
    checkField("onehot", 32'(onehot), 32'(x.onehot));
    cycle_no++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      checkOutput();
    end
  end

  initial begin
    logic [1:0] cur_mode;
    bit         cur_sw;
    int         en_bias;
    bit         r;
    bit         l;
    bit         e;
    cur_mode = 2'b00;
    cur_sw   = 1'b0;
    en_bias  = 10;
    $display("[TB] starting randomised run");
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      if ($urandom_range(0, 79) == 0) cur_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) cur_sw = ~cur_sw;
      if ($urandom_range(0, 99) == 0) en_bias = $urandom_range(3, 10);
      r = (c < 2) || ($urandom_range(0, 299) == 0);
      l = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 9) < en_bias);
      applyStimulus(r, l, e, cur_sw, cur_mode, WD'($urandom_range(0, 7)));
    end
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
